ines_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 53 +++++
 rtl/loader_refresh_timer.sv | 40 ++++
 rtl/ines_loader.sv | 169 ++++++++++++++++
 tb/tb_ines_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the iNES / NES 2.0 cartridge loader.
// Header byte offsets, state encodings, error codes and mapper_flags bit positions.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HEADER  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_TRAINER = 3'd2,
        ST_PRG     = 3'd3,
        ST_CHR     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_MAGIC  = 2'd1;
    localparam logic [1:0] ERR_FORMAT = 2'd2;
    localparam logic [1:0] ERR_SIZE   = 2'd3;

    localparam int HDR_MAGIC    = 0;
    localparam int HDR_PRG_LSB  = 4;
    localparam int HDR_CHR_LSB  = 5;
    localparam int HDR_FLAGS6   = 6;
    localparam int HDR_FLAGS7   = 7;
    localparam int HDR_MAPPER8  = 8;
    localparam int HDR_SIZE_MSB = 9;
    localparam int HDR_BYTES    = 10;

    localparam logic [31:0] MAGIC_WORD    = 32'h1A53454E;
    localparam int          TRAINER_BYTES = 512;

    localparam int MF_MAPPER_LO   = 0;
    localparam int MF_PRG_SIZE    = 8;
    localparam int MF_CHR_SIZE    = 11;
    localparam int MF_MIRROR      = 14;
    localparam int MF_CHR_RAM     = 15;
    localparam int MF_FOUR_SCREEN = 16;
    localparam int MF_BATTERY     = 17;
    localparam int MF_MAPPER_HI   = 18;
    localparam int MF_SUBMAPPER   = 22;
    localparam int MF_NES2        = 26;

    // ceil(log2(units)) saturating at 7; zero units report 0
    function automatic logic [2:0] size_log2(input logic [11:0] units);
        logic [2:0] r;
        r = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if ({20'd0, units} <= (32'd1 << k)) r = 3'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/loader_refresh_timer.sv
// Issues SDRAM refresh pulses every REFRESH_GAP idle cycles, REFRESH_COUNT times after each write.
// Pulse is registered, then masked on write cycles and when disabled.
module loader_refresh_timer #(
    parameter int REFRESH_GAP   = 8,
    parameter int REFRESH_COUNT = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic write,
    input  logic enable,
    output logic refresh
);
    localparam int              RMAX     = REFRESH_GAP * REFRESH_COUNT;
    localparam int              RW       = $clog2(RMAX + 1);
    localparam logic [RW-1:0]   RCNT_MAX = RW'(RMAX);
    localparam logic [RW-1:0]   PHASE    = RW'(REFRESH_GAP - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          refresh_q;

    always_comb begin
        rcnt_d = rcnt_q;
        if (write)                  rcnt_d = '0;
        else if (rcnt_q != RCNT_MAX) rcnt_d = rcnt_q + 1'b1;
    end

    // Counter starts saturated so nothing is refreshed before the first write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rcnt_q    <= RCNT_MAX;
            refresh_q <= 1'b0;
        end else begin
            rcnt_q    <= rcnt_d;
            refresh_q <= ((rcnt_d & PHASE) == PHASE) && (rcnt_d != RCNT_MAX);
        end
    end

    assign refresh = refresh_q && enable && !write;

endmodule

// File: rtl/ines_loader.sv
// Parses an iNES/NES 2.0 header, skips the trainer and streams PRG then CHR bytes into SDRAM.
// Byte-level valid/ready; stalls on mem_busy while loading, swallows bytes once finished.
module ines_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W          = 22,
    parameter logic [ADDR_W-1:0] CHR_BASE        = 22'h200000,
    parameter int                REFRESH_GAP     = 8,
    parameter int                REFRESH_COUNT   = 6,
    parameter bit                SUPPORT_TRAINER = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [31:0]       mapper_flags,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [2:0]        loader_state,
    output logic [ADDR_W:0]   bytes_left
);
    localparam int          LW        = ADDR_W + 1;
    localparam logic [39:0] PRG_LIMIT = 40'(CHR_BASE);
    localparam logic [39:0] CHR_LIMIT = (40'd1 << ADDR_W) - 40'(CHR_BASE);

    state_e                     state_q;
    logic [3:0]                 ctr_q;
    logic [HDR_BYTES-1:0][7:0]  hdr_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [LW-1:0]              bytes_left_q;
    logic                       done_q, error_q;
    logic [1:0]                 err_code_q;

    logic        accept, last, nes2, trainer, fmt_bad, size_bad, unused_hdr;
    logic [11:0] prg_units, chr_units;
    logic [39:0] prg_bytes, chr_bytes;

    assign nes2       = hdr_q[HDR_FLAGS7][3:2] == 2'b10;
    assign trainer    = hdr_q[HDR_FLAGS6][2];
    assign prg_units  = {nes2 ? hdr_q[HDR_SIZE_MSB][3:0] : 4'h0, hdr_q[HDR_PRG_LSB]};
    assign chr_units  = {nes2 ? hdr_q[HDR_SIZE_MSB][7:4] : 4'h0, hdr_q[HDR_CHR_LSB]};
    assign prg_bytes  = {14'd0, prg_units, 14'd0};
    assign chr_bytes  = {15'd0, chr_units, 13'd0};
    assign fmt_bad    = (prg_units[11:8] == 4'hF) || (chr_units[11:8] == 4'hF)
                      || (trainer && !SUPPORT_TRAINER);
    assign size_bad   = (prg_units == '0) || (prg_bytes > PRG_LIMIT) || (chr_bytes > CHR_LIMIT);
    assign unused_hdr = ^hdr_q[HDR_FLAGS7][1:0];

    always_comb begin
        case (state_q)
            ST_HEADER, ST_TRAINER, ST_PRG, ST_CHR: in_ready = !mem_busy;
            ST_DONE, ST_ERROR:                     in_ready = 1'b1;
            default:                               in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign last      = bytes_left_q == LW'(1);
    assign mem_write = accept && (state_q == ST_PRG || state_q == ST_CHR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_HEADER;
            ctr_q        <= '0;
            hdr_q        <= '0;
            mem_addr_q   <= '0;
            bytes_left_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            case (state_q)
                ST_HEADER: if (accept) begin
                    // Bytes 10..15 are padding/unused fields and are not kept.
                    if (ctr_q < 4'(HDR_BYTES)) hdr_q[ctr_q] <= in_data;
                    ctr_q <= ctr_q + 1'b1;
                    if (ctr_q == 4'd15) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    mem_addr_q <= '0;
                    if (hdr_q[HDR_MAGIC+3:HDR_MAGIC] != MAGIC_WORD) begin
                        state_q <= ST_ERROR; error_q <= 1'b1; err_code_q <= ERR_MAGIC;
                    end else if (fmt_bad) begin
                        state_q <= ST_ERROR; error_q <= 1'b1; err_code_q <= ERR_FORMAT;
                    end else if (size_bad) begin
                        state_q <= ST_ERROR; error_q <= 1'b1; err_code_q <= ERR_SIZE;
                    end else if (trainer) begin
                        state_q      <= ST_TRAINER;
                        bytes_left_q <= LW'(TRAINER_BYTES);
                    end else begin
                        state_q      <= ST_PRG;
                        bytes_left_q <= LW'(prg_bytes);
                    end
                end
                ST_TRAINER: if (accept) begin
                    bytes_left_q <= bytes_left_q - 1'b1;
                    if (last) begin
                        state_q      <= ST_PRG;
                        bytes_left_q <= LW'(prg_bytes);
                    end
                end
                ST_PRG: if (accept) begin
                    mem_addr_q   <= mem_addr_q + 1'b1;
                    bytes_left_q <= bytes_left_q - 1'b1;
                    if (last) begin
                        if (chr_units == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= ST_CHR;
                            mem_addr_q   <= CHR_BASE;
                            bytes_left_q <= LW'(chr_bytes);
                        end
                    end
                end
                ST_CHR: if (accept) begin
                    mem_addr_q   <= mem_addr_q + 1'b1;
                    bytes_left_q <= bytes_left_q - 1'b1;
                    if (last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mapper_flags                       = '0;
        mapper_flags[MF_MAPPER_LO +: 8]    = {hdr_q[HDR_FLAGS7][7:4], hdr_q[HDR_FLAGS6][7:4]};
        mapper_flags[MF_PRG_SIZE +: 3]     = size_log2(prg_units);
        mapper_flags[MF_CHR_SIZE +: 3]     = size_log2(chr_units);
        mapper_flags[MF_MIRROR]            = hdr_q[HDR_FLAGS6][0];
        mapper_flags[MF_CHR_RAM]           = chr_units == '0;
        mapper_flags[MF_FOUR_SCREEN]       = hdr_q[HDR_FLAGS6][3];
        mapper_flags[MF_BATTERY]           = hdr_q[HDR_FLAGS6][1];
        mapper_flags[MF_MAPPER_HI +: 4]    = nes2 ? hdr_q[HDR_MAPPER8][3:0] : 4'h0;
        mapper_flags[MF_SUBMAPPER +: 4]    = nes2 ? hdr_q[HDR_MAPPER8][7:4] : 4'h0;
        mapper_flags[MF_NES2]              = nes2;
    end

    loader_refresh_timer #(
        .REFRESH_GAP   (REFRESH_GAP),
        .REFRESH_COUNT (REFRESH_COUNT)
    ) u_refresh (
        .clk     (clk),
        .reset_n (reset_n),
        .write   (mem_write),
        .enable  (state_q != ST_DONE && state_q != ST_ERROR),
        .refresh (mem_refresh)
    );

    assign mem_addr     = mem_addr_q;
    assign mem_data     = in_data;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign loader_state = state_q;
    assign bytes_left   = bytes_left_q;

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: header decode, section sequencing, errors, backpressure, refresh.
module tb_ines_loader;
    typedef logic [15:0][7:0] hdr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_busy = 1'b0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic        mem_refresh;
    logic [31:0] mapper_flags;
    logic        done, error;
    logic [1:0]  err_code;
    logic [2:0]  loader_state;
    logic [22:0] bytes_left;

    ines_loader dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_busy(mem_busy), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_write(mem_write), .mem_refresh(mem_refresh), .mapper_flags(mapper_flags),
        .done(done), .error(error), .err_code(err_code), .loader_state(loader_state),
        .bytes_left(bytes_left)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int prg_len = 0, trn_len = 0, wr_base = 0;
    int wr_total = 0, addr_errs = 0, data_errs = 0;
    int ref_total = 0, ref_bad = 0, cyc = 0, last_wr_cyc = 0;
    int ref_off [64];
    int stall_cnt = 0, hold_errs = 0, timeouts = 0;
    logic tog_en = 1'b0, tog = 1'b0, aborted = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7) ^ (i >> 8));
    endfunction

    function automatic int exp_addr(input int k);
        return (k < prg_len) ? k : 32'h200000 + (k - prg_len);
    endfunction

    function automatic hdr_t make_hdr(input logic [7:0] prg, chr, f6, f7, b8, b9);
        hdr_t h;
        h = '0;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
        h[4] = prg; h[5] = chr; h[6] = f6; h[7] = f7; h[8] = b8; h[9] = b9;
        return h;
    endfunction

    // Write scoreboard: k-th write of a load carries payload byte k+trn_len at exp_addr(k).
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            if (32'(mem_addr) !== exp_addr(wr_total - wr_base)) addr_errs <= addr_errs + 1;
            if (mem_data !== pat(wr_total - wr_base + trn_len)) data_errs <= data_errs + 1;
            wr_total    <= wr_total + 1;
            last_wr_cyc <= cyc;
        end
        if (mem_refresh) begin
            if (mem_write || loader_state >= 3'd5) ref_bad <= ref_bad + 1;
            ref_off[ref_total % 64] <= cyc - last_wr_cyc;
            ref_total <= ref_total + 1;
        end
    end

    task automatic send(input logic [7:0] b);
        int   guard;
        logic acc;
        logic [21:0] addr_s;
        logic [22:0] left_s;
        guard = 0;
        if (aborted) return;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            if (tog_en) begin mem_busy = tog; tog = !tog; end
            @(negedge clk);
            acc = in_ready;
            addr_s = mem_addr;
            left_s = bytes_left;
            @(posedge clk); #1;
            if (acc) break;
            stall_cnt++;
            if (mem_addr !== addr_s || bytes_left !== left_s) hold_errs++;
            guard++;
            if (guard > 200) begin timeouts++; aborted = 1'b1; break; end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        mem_busy = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic load_hdr(input hdr_t h);
        do_reset();
        for (int i = 0; i < 16; i++) send(h[i]);
    endtask

    initial begin
        #6_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, s0, h0;

        // Reset state
        do_reset();
        check_eq("rst_state", loader_state, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_left", bytes_left, 0);
        check_eq("rst_flags", {done, error, err_code, mem_refresh}, 0);
        check_eq("rst_ready", in_ready, 1);

        // iNES PRG=2 CHR=1 mapper 1, horizontal bit set
        r0 = ref_total;
        load_hdr(make_hdr(8'd2, 8'd1, 8'h11, 8'h00, 8'h00, 8'h00));
        check_eq("a_check_state", loader_state, 1);
        check_eq("a_check_ready", in_ready, 0);
        idle(1);
        check_eq("a_prg_state", loader_state, 3);
        check_eq("a_prg_left", bytes_left, 32768);
        check_eq("a_hdr_no_refresh", ref_total - r0, 0);
        prg_len = 32768; trn_len = 0; wr_base = wr_total; w0 = wr_total;
        for (int i = 0; i < 32768; i++) send(pat(i));
        check_eq("a_chr_state", loader_state, 4);
        check_eq("a_chr_addr", mem_addr, 22'h200000);
        check_eq("a_chr_left", bytes_left, 8192);
        for (int i = 32768; i < 40959; i++) send(pat(i));
        check_eq("a_last_left", bytes_left, 1);
        check_eq("a_done_early", done, 0);
        send(pat(40959));
        check_eq("a_done", done, 1);
        check_eq("a_done_state", loader_state, 5);
        check_eq("a_writes", wr_total - w0, 40960);
        check_eq("a_addr_seq", addr_errs, 0);
        check_eq("a_data", data_errs, 0);
        check_eq("a_mapper_flags", mapper_flags, 32'h00004101);
        r0 = ref_total;
        idle(60);
        check_eq("a_done_no_refresh", ref_total - r0, 0);

        // Bad magic
        w0 = wr_total;
        begin
            hdr_t h;
            h = make_hdr(8'd2, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00);
            h[0] = 8'h4D;
            load_hdr(h);
        end
        check_eq("b_check_state", loader_state, 1);
        idle(1);
        check_eq("b_state", loader_state, 6);
        check_eq("b_error", {error, done}, 2'b10);
        check_eq("b_code", err_code, 1);
        mem_busy = 1'b1;
        #1 check_eq("b_ready_busy", in_ready, 1);
        for (int i = 0; i < 5; i++) send(8'hAA);
        mem_busy = 1'b0;
        check_eq("b_no_write", wr_total - w0, 0);

        // Trainer, PRG=1, CHR=0, busy toggle and refresh window
        load_hdr(make_hdr(8'd1, 8'd0, 8'h04, 8'h00, 8'h00, 8'h00));
        idle(1);
        check_eq("c_trn_state", loader_state, 2);
        check_eq("c_trn_left", bytes_left, 512);
        prg_len = 16384; trn_len = 512; wr_base = wr_total; w0 = wr_total;
        addr_errs = 0; data_errs = 0;
        for (int i = 0; i < 512; i++) send(pat(i));
        check_eq("c_trn_no_write", wr_total - w0, 0);
        check_eq("c_prg_state", loader_state, 3);
        check_eq("c_prg_left", bytes_left, 16384);
        s0 = stall_cnt; h0 = hold_errs;
        tog = 1'b0; tog_en = 1'b1;
        for (int i = 512; i < 544; i++) send(pat(i));
        tog_en = 1'b0; mem_busy = 1'b0;
        check_eq("c_bp_writes", wr_total - w0, 32);
        check_eq("c_bp_stalls", stall_cnt - s0, 31);
        check_eq("c_bp_hold", hold_errs - h0, 0);
        for (int i = 544; i < 612; i++) send(pat(i));
        r0 = ref_total;
        idle(60);
        check_eq("c_ref_count", ref_total - r0, 6);
        for (int j = 0; j < 6; j++) check_eq("c_ref_offset", ref_off[(r0 + j) % 64], 8 * (j + 1));
        for (int i = 612; i < 16896; i++) send(pat(i));
        check_eq("c_done", done, 1);
        check_eq("c_writes", wr_total - w0, 16384);
        check_eq("c_addr_seq", addr_errs, 0);
        check_eq("c_data", data_errs, 0);
        check_eq("c_mapper_flags", mapper_flags, 32'h00008000);

        // Header error and size boundary cases
        load_hdr(make_hdr(8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h01));
        idle(1);
        check_eq("d_nes2_4mb", {error, err_code}, 3'b111);
        load_hdr(make_hdr(8'h01, 8'h00, 8'h00, 8'h08, 8'h00, 8'hF0));
        idle(1);
        check_eq("d_exponent", {error, err_code}, 3'b110);
        load_hdr(make_hdr(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
        idle(1);
        check_eq("d_prg_zero", {error, err_code}, 3'b111);
        load_hdr(make_hdr(8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        idle(1);
        check_eq("d_prg_129", {error, err_code}, 3'b111);
        load_hdr(make_hdr(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        idle(1);
        check_eq("d_prg_128_state", loader_state, 3);
        check_eq("d_prg_128_left", bytes_left, 23'h200000);
        check_eq("d_prg_128_flags", mapper_flags, 32'h00008700);

        // NES 2.0 flag decode, then reset mid-PRG
        load_hdr(make_hdr(8'd3, 8'd2, 8'h0A, 8'h08, 8'h35, 8'h00));
        idle(1);
        check_eq("e_state", loader_state, 3);
        check_eq("e_left", bytes_left, 49152);
        check_eq("e_mapper_flags", mapper_flags, 32'h04D70A00);
        prg_len = 49152; trn_len = 0; wr_base = wr_total;
        for (int i = 0; i < 10; i++) send(pat(i));
        check_eq("e_mid_addr", mem_addr, 10);
        check_eq("e_mid_left", bytes_left, 49142);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_eq("e_rst_state", loader_state, 0);
        check_eq("e_rst_addr", mem_addr, 0);
        check_eq("e_rst_left", bytes_left, 0);
        reset_n = 1'b1;

        check_eq("refresh_rules", ref_bad, 0);
        check_eq("timeouts", timeouts, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
